// File: rtl/inst_fetch_issue_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_issue_if
// Bundles the fetch stage's bus signals into one interface.
//   imem_addr   [15:0]  fetch -> imem : read address (the registered PC)
//   imem_en             fetch -> imem : read strobe; data returns one cycle later
//   imem_rdata  [15:0]  imem  -> fetch: read data
//   stall               hazard -> fetch: hold the IF/ID register
//   redirect            EX    -> fetch: taken branch (wins over stall)
//   redirect_pc [15:0]  EX    -> fetch: branch target
//   inst        [15:0]  fetch -> decode: IF/ID instruction
//   inst_pc     [15:0]  fetch -> decode: address of inst
//   inst_valid          fetch -> decode: inst is a fetched word, not a bubble
//   halted              fetch -> core  : fetch stopped on HLT
// master = the fetch stage, slave = the surrounding pipeline/memory.
// -----------------------------------------------------------------------------
interface inst_fetch_issue_if;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        halted;

  modport master (
    output imem_addr, imem_en, inst, inst_pc, inst_valid, halted,
    input  imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, imem_en, inst, inst_pc, inst_valid, halted,
    output imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/inst_fetch_issue.sv
// -----------------------------------------------------------------------------
// inst_fetch_issue
// Fetch/issue stage of the pipelined SIMPLE core. Drives the synchronous
// instruction memory, keeps a one-entry skid buffer so the word in flight
// during a stall is never dropped, and builds the IF/ID register. Handles
// branch redirect (two bubbles) and stops fetching when a HLT word issues.
// Ports:
//   clk       : single clock, rising edge
//   rst       : synchronous, active-high reset
//   io_fetch  : inst_fetch_issue_if.master (see interface file for signals)
// Parameters:
//   RESET_PC  : first word address fetched after reset
//   NOP_INST  : bubble word placed in the IR when nothing valid is issued
// -----------------------------------------------------------------------------
module inst_fetch_issue #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'hC070
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_issue_if.master  io_fetch
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_pc;
  logic [15:0] r_pc_d;
  logic        r_rd_valid;
  logic [15:0] r_skid;
  logic [15:0] r_skid_pc;
  logic        r_skid_full;
  logic [15:0] r_inst;
  logic [15:0] r_inst_pc;
  logic        r_inst_valid;

  logic        w_run_load;   // RUN, no stall, no redirect: IR advances, read issues
  logic        w_load_word;  // a real word is available to load into the IR
  logic [15:0] w_load_inst;
  logic [15:0] w_load_pc;
  logic        w_load_hlt;
  logic        w_skid_cap;

  assign w_run_load  = (r_state == RUN) && !io_fetch.stall && !io_fetch.redirect;
  assign w_load_word = r_skid_full || r_rd_valid;
  // The skid holds the older word, so it always drains before fresh read data.
  assign w_load_inst = r_skid_full ? r_skid    : io_fetch.imem_rdata;
  assign w_load_pc   = r_skid_full ? r_skid_pc : r_pc_d;
  assign w_load_hlt  = (w_load_inst[15:14] == 2'b11) && (w_load_inst[7:4] == 4'hF);
  // Park the returning word while the IR is frozen; nothing else is issued
  // during a stall, so the skid cannot be needed twice.
  assign w_skid_cap  = (r_state == RUN) && !io_fetch.redirect && io_fetch.stall &&
                       r_rd_valid && !r_skid_full;

  // ---------------------------------------------------------------- FSM state
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  // ----------------------------------------------------------- FSM next state
  // NOTE: default assignment first so no path leaves w_state_nxt unassigned
  // (which would infer a latch).
  always_comb begin
    w_state_nxt = r_state;
    if (io_fetch.redirect) begin
      w_state_nxt = RUN;  // also cancels a speculatively fetched HLT
    end else if (w_run_load && w_load_word && w_load_hlt) begin
      w_state_nxt = HALT;
    end
  end

  // --------------------------------------------------------------- FSM outputs
  always_comb begin
    io_fetch.imem_en = !rst && w_run_load;
    io_fetch.halted  = (r_state == HALT);
  end

  assign io_fetch.imem_addr  = r_pc;
  assign io_fetch.inst       = r_inst;
  assign io_fetch.inst_pc    = r_inst_pc;
  assign io_fetch.inst_valid = r_inst_valid;

  // ------------------------------------------------------- PC, IR, flag state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_rd_valid   <= 1'b0;
      r_skid_full  <= 1'b0;
      r_inst       <= NOP_INST;
      r_inst_pc    <= 16'h0000;
      r_inst_valid <= 1'b0;
    end else begin
      // A read is live next cycle only if one issued now; this also squashes
      // the in-flight read on redirect and ignores rdata in HALT.
      r_rd_valid <= w_run_load;
      if (io_fetch.redirect) begin
        r_pc         <= io_fetch.redirect_pc;
        r_inst       <= NOP_INST;
        r_inst_valid <= 1'b0;
        r_skid_full  <= 1'b0;
      end else if (r_state == HALT) begin
        // HLT stays visible until the first non-stall edge, then bubbles.
        if (!io_fetch.stall) begin
          r_inst       <= NOP_INST;
          r_inst_valid <= 1'b0;
        end
      end else if (io_fetch.stall) begin
        if (w_skid_cap) r_skid_full <= 1'b1;
      end else begin
        r_pc        <= r_pc + 16'd1;
        r_skid_full <= 1'b0;
        if (w_load_word) begin
          r_inst       <= w_load_inst;
          r_inst_pc    <= w_load_pc;
          r_inst_valid <= 1'b1;
        end else begin
          r_inst       <= NOP_INST;
          r_inst_valid <= 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------- data-only registers
  // NOTE: these hold payload only; they are qualified by r_rd_valid /
  // r_skid_full, which are reset, so they need no reset of their own.
  always_ff @(posedge clk) begin
    if (w_run_load) r_pc_d <= r_pc;
    if (w_skid_cap) begin
      r_skid    <= io_fetch.imem_rdata;
      r_skid_pc <= r_pc_d;
    end
  end

endmodule

// File: doc/inst_fetch_issue.md
# inst_fetch_issue

Instruction fetch/issue stage for the pipelined SIMPLE core. Drives addresses into the synchronous instruction memory and assembles the IF/ID instruction register whose `inst` output feeds the control decoder. Handles pipeline stall, branch redirect, and HLT detection, including bubble (NOP) insertion.

## Interface
- `RESET_PC`, 16'h0000: word address fetched first after reset.
- `NOP_INST`, 16'hC070: bubble word (class 11, op 0111). The decoder produces no register write, memory access, I/O or halt for this word.
- `clk`  in  1: the single clock. All state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_addr`  out  16: read address (registered PC).
- `imem_en`  out  1: read strobe. `imem_rdata` is valid exactly one cycle after a cycle with `imem_en`=1.
- `imem_rdata`  in  16: instruction memory read data.
- `stall`  in  1: hold the IF/ID register, from hazard logic.
- `redirect`  in  1: taken branch, from EX. Priority over `stall`.
- `redirect_pc`  in  16: branch target.
- `inst`  out  16: IF/ID instruction, to the control decoder.
- `inst_pc`  out  16: address of `inst`.
- `inst_valid`  out  1: `inst` is a real fetched word, not a bubble.
- `halted`  out  1: fetch stopped on HLT.

## Operation
- **State**
  - FSM states: RUN, HALT.
  - `pc` (= `imem_addr`).
  - `pc_d`: address of the in-flight read.
  - `rd_valid`: a read is in flight and not squashed.
  - One-entry skid buffer: `skid`, `skid_pc`, `skid_full`.
  - IR: `inst`, `inst_pc`, `inst_valid`.
- **Reset values:** FSM=RUN, `pc`=RESET_PC, `imem_en`=0, `rd_valid`=0, `skid_full`=0, `inst`=NOP_INST, `inst_pc`=0, `inst_valid`=0, `halted`=0.
- **Read issue:** `imem_en` = !rst & FSM==RUN & !stall & !redirect.
  - On an issuing edge: `pc_d`<=`pc`, `pc`<=`pc`+1 (16-bit wrap, FFFF->0000), `rd_valid`<=1.
  - Otherwise `rd_valid`<=0.
- **IR load, RUN, no stall, no redirect** (first true entry wins):
  1. `skid_full`: IR<={skid,skid_pc,1}, and `skid_full`<=0.
  2. `rd_valid`: IR<={imem_rdata,pc_d,1}.
  3. Otherwise: IR<={NOP_INST,`inst_pc`,0}.
- **Stall (RUN, no redirect)**
  - IR holds.
  - If `rd_valid` and skid empty: skid<={imem_rdata,pc_d} and `skid_full`<=1. The in-flight word is never lost.
  - `pc` holds; no read is issued.
- **Redirect (any state)**
  - `pc`<=`redirect_pc`.
  - IR<=NOP/valid 0; `skid_full`<=0; `rd_valid`<=0 (squashes the in-flight read).
  - FSM<=RUN; `halted`<=0.
- **HLT detect:** a word with [15:14]=11 and [7:4]=1111 loaded into IR (from rdata or skid) sets FSM<=HALT at that same edge.
- **HALT state**
  - `halted`=1, `imem_en`=0, `pc` holds, and `imem_rdata` is ignored.
  - IR keeps HLT until the first non-stall edge, then loads NOP/valid 0.
  - Only `redirect` or `rst` leaves HALT. A redirect cancels a speculatively fetched HLT.

## Timing
- Fetch-to-issue latency is 2 edges: the address is presented in cycle n, the word appears on `inst` after edge n+1.
- Reset release: first `imem_en`=1 in the cycle after `rst` falls; first valid `inst` 2 edges later.
- Redirect sampled at edge E0: `imem_addr`=target after E0; `inst`=mem[target] after E0+2. Exactly 2 bubbles.
- Stall asserted for k cycles: `inst` constant for those k cycles. The word following it appears at the first edge with `stall`=0, with no bubble.
- `redirect` together with `stall`: redirect wins; IR becomes NOP.
- `rst` mid-stall, mid-redirect or in HALT: all state returns to its reset values at that edge.

## Test plan
- **Sequential fetch:** mem[0..3]=C000,C110,C220,C330, no stall. `inst`=C000 after the 2nd edge post-reset, then one word per cycle; `inst_pc`=0,1,2,3; `inst_valid`=1.
- **Stall:** assert `stall` for 3 cycles while `inst`=C110. `inst` stays C110 for 3 cycles, then C220, C330 with no gap. Skid used; no address skipped.
- **Redirect:** `redirect`=1 with `redirect_pc`=0x0040 while `inst`=C220. Next 2 cycles `inst`=C070 with `inst_valid`=0, then mem[0x40] with `inst_pc`=0x0040.
- **Halt:** mem[2]=C0F0. `inst`=C0F0 for one cycle, then `halted`=1, `imem_en`=0 and `inst`=C070 indefinitely.
- **Speculative halt cancel:** redirect to 0x0010 on the cycle after HLT issues. `halted` returns to 0 and mem[0x10] issues 2 edges later.
- **Wrap and simultaneous events:** RESET_PC=FFFF gives fetch order FFFF, 0000. `stall`+`redirect` in the same cycle: redirect taken. `rst` during a stall: `inst`=C070, `skid_full`=0.
